// File: rtl/mu0_arb_pkg.sv
// mu0_arb_pkg: shared definitions for the MU0 memory-port arbiter.
//   state_t  : arbiter FSM states (IDLE, ACCESS, WAIT, ACK)
//   OWN_CORE : owner/grant id of the core port (C)
//   OWN_DBG  : owner/grant id of the debug/loader port (D)
package mu0_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_ACK    = 2'd3
  } state_t;

  localparam logic OWN_CORE = 1'b0;
  localparam logic OWN_DBG  = 1'b1;

endpackage

// File: rtl/mu0_arb_rr.sv
// mu0_arb_rr: combinational two-way round-robin picker.
// Ports:
//   c_req, d_req : pending requests from core / debug port
//   owner        : port granted last (OWN_CORE / OWN_DBG)
//   lock         : debug lock; forces D to win a tie while D owns the port
//   grant_valid  : at least one request pending
//   grant_id     : winning port (OWN_CORE / OWN_DBG)
module mu0_arb_rr
  import mu0_arb_pkg::*;
(
  input  logic c_req,
  input  logic d_req,
  input  logic owner,
  input  logic lock,
  output logic grant_valid,
  output logic grant_id
);

  // D wins when it is the only requester, when the core had the last grant,
  // or when locked. Lock only matters on a tie with owner == OWN_DBG, because
  // with owner == OWN_CORE the tie already goes to D.
  always_comb begin
    grant_valid = c_req | d_req;
    grant_id    = OWN_CORE;
    if (d_req && (!c_req || (owner == OWN_CORE) || lock)) begin
      grant_id = OWN_DBG;
    end
  end

endmodule

// File: rtl/mu0_mem_arbiter.sv
// mu0_mem_arbiter: shares MU0's single memory port between the core (C)
// and a debug/program loader (D) with round-robin arbitration.
// Optional feature macro: MU0_ARB_LOCK_EN (adds d_lock input).
// Ports:
//   Clk, Reset                      : clock, synchronous active-high reset
//   c_req/c_wr/c_addr/c_wdata       : core request, held until c_ack
//   c_ack, c_rdata                  : core completion pulse, read data
//   d_req/d_wr/d_addr/d_wdata       : debug request, held until d_ack
//   d_ack, d_rdata                  : debug completion pulse, read data
//   d_lock                          : (MU0_ARB_LOCK_EN only) keep D granted
//   mem_rd/mem_wr                   : one-cycle memory strobes
//   mem_addr/mem_wdata/mem_rdata    : memory address / write / read data
//   owner                           : last granted port (0 core, 1 debug)
//   busy                            : high whenever not IDLE
module mu0_mem_arbiter
  import mu0_arb_pkg::*;
#(
  parameter int AW      = 12,
  parameter int DW      = 16,
  parameter int MEM_LAT = 1
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          c_req,
  input  logic          c_wr,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_ack,
  output logic [DW-1:0] c_rdata,
  input  logic          d_req,
  input  logic          d_wr,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
`ifdef MU0_ARB_LOCK_EN
  input  logic          d_lock,
`endif
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          owner,
  output logic          busy
);

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_t        r_state;
  state_t        w_next;
  logic          r_owner;
  logic          r_wr;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_c_rdata;
  logic [DW-1:0] r_d_rdata;
  logic [3:0]    r_cnt;
  logic          w_grant_valid;
  logic          w_grant_id;
  logic          w_lock;

`ifdef MU0_ARB_LOCK_EN
  assign w_lock = d_lock;
`else
  assign w_lock = 1'b0;
`endif

  mu0_arb_rr u_rr (
    .c_req       (c_req),
    .d_req       (d_req),
    .owner       (r_owner),
    .lock        (w_lock),
    .grant_valid (w_grant_valid),
    .grant_id    (w_grant_id)
  );

  always_ff @(posedge Clk) begin
    if (Reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next state plus outputs decoded from state and registered latches only.
  always_comb begin
    w_next    = r_state;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    c_ack     = 1'b0;
    d_ack     = 1'b0;
    busy      = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: begin
        if (w_grant_valid) w_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        mem_rd = ~r_wr;
        mem_wr = r_wr;
        w_next = r_wr ? ST_ACK : ST_WAIT;
      end
      ST_WAIT: begin
        if (r_cnt == '0) w_next = ST_ACK;
      end
      ST_ACK: begin
        c_ack  = (r_owner == OWN_CORE);
        d_ack  = (r_owner == OWN_DBG);
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_owner   <= OWN_DBG;
      r_wr      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_c_rdata <= '0;
      r_d_rdata <= '0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant_valid) begin
            r_owner <= w_grant_id;
            r_wr    <= (w_grant_id == OWN_DBG) ? d_wr    : c_wr;
            r_addr  <= (w_grant_id == OWN_DBG) ? d_addr  : c_addr;
            r_wdata <= (w_grant_id == OWN_DBG) ? d_wdata : c_wdata;
          end
        end
        ST_ACCESS: r_cnt <= LAT_M1;
        ST_WAIT: begin
          if (r_cnt == '0) begin
            if (r_owner == OWN_DBG) r_d_rdata <= mem_rdata;
            else                    r_c_rdata <= mem_rdata;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign c_rdata   = r_c_rdata;
  assign d_rdata   = r_d_rdata;
  assign owner     = r_owner;

endmodule

// File: tb/tb_mu0_mem_arbiter.sv
// tb_mu0_mem_arbiter: directed self-checking bench for mu0_mem_arbiter.
// dut1 uses MEM_LAT=1, dut3 uses MEM_LAT=3; each has a memory model that
// returns valid data only exactly MEM_LAT cycles after the read strobe.
// With MU0_ARB_LOCK_EN defined the d_lock scenario is also exercised.
module tb_mu0_mem_arbiter;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // dut1 (MEM_LAT = 1)
  logic        c_req, c_wr, d_req, d_wr;
  logic [11:0] c_addr, d_addr;
  logic [15:0] c_wdata, d_wdata;
  logic        c_ack, d_ack, mem_rd, mem_wr, owner, busy;
  logic [15:0] c_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [11:0] mem_addr;
`ifdef MU0_ARB_LOCK_EN
  logic        d_lock;
`endif

  // dut3 (MEM_LAT = 3), core port only
  logic        k_c_req;
  logic [11:0] k_c_addr;
  logic        k_c_ack, k_d_ack, k_mem_rd, k_mem_wr, k_owner, k_busy;
  logic [15:0] k_c_rdata, k_d_rdata, k_mem_wdata, k_mem_rdata;
  logic [11:0] k_mem_addr;
  logic        k_s1, k_s2;
  logic [11:0] k_a1, k_a2;

  mu0_mem_arbiter #(.AW(12), .DW(16), .MEM_LAT(1)) dut1 (
    .Clk(Clk), .Reset(Reset),
    .c_req(c_req), .c_wr(c_wr), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_ack(c_ack), .c_rdata(c_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
`ifdef MU0_ARB_LOCK_EN
    .d_lock(d_lock),
`endif
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .owner(owner), .busy(busy)
  );

  mu0_mem_arbiter #(.AW(12), .DW(16), .MEM_LAT(3)) dut3 (
    .Clk(Clk), .Reset(Reset),
    .c_req(k_c_req), .c_wr(1'b0), .c_addr(k_c_addr), .c_wdata(16'h0000),
    .c_ack(k_c_ack), .c_rdata(k_c_rdata),
    .d_req(1'b0), .d_wr(1'b0), .d_addr(12'h000), .d_wdata(16'h0000),
    .d_ack(k_d_ack), .d_rdata(k_d_rdata),
`ifdef MU0_ARB_LOCK_EN
    .d_lock(1'b0),
`endif
    .mem_rd(k_mem_rd), .mem_wr(k_mem_wr), .mem_addr(k_mem_addr),
    .mem_wdata(k_mem_wdata), .mem_rdata(k_mem_rdata),
    .owner(k_owner), .busy(k_busy)
  );

  function automatic logic [15:0] memval(input logic [11:0] a);
    if (a == 12'h005) return 16'hBEEF;
    return {4'hC, a};
  endfunction

  // Read data is valid only MEM_LAT cycles after the strobe, else 0BAD.
  always @(posedge Clk) mem_rdata <= mem_rd ? memval(mem_addr) : 16'h0BAD;

  always @(posedge Clk) begin
    k_s1        <= k_mem_rd;
    k_a1        <= k_mem_addr;
    k_s2        <= k_s1;
    k_a2        <= k_a1;
    k_mem_rdata <= k_s2 ? memval(k_a2) : 16'h0BAD;
  end

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    tick; tick;
    checks++;
    if ({busy, owner, c_ack, d_ack, mem_rd, mem_wr} !== 6'b010000) begin
      errors++;
      $display("FAIL reset_ctl: got %b want 010000", {busy, owner, c_ack, d_ack, mem_rd, mem_wr});
    end
    checks++;
    if ({mem_addr, mem_wdata, c_rdata, d_rdata} !== 60'h0) begin
      errors++;
      $display("FAIL reset_data: got %h want 0", {mem_addr, mem_wdata, c_rdata, d_rdata});
    end
    checks++;
    if ({k_busy, k_owner} !== 2'b01) begin
      errors++;
      $display("FAIL reset_dut3: got %b want 01", {k_busy, k_owner});
    end
  endtask

  task automatic test_core_read;
    Reset = 1'b0; c_req = 1'b1; c_wr = 1'b0; c_addr = 12'h005;
    tick;
    checks++;
    if ({mem_rd, mem_wr, busy, owner, mem_addr} !== {4'b1010, 12'h005}) begin
      errors++;
      $display("FAIL t1_access: got %b/%h want 1010/005", {mem_rd, mem_wr, busy, owner}, mem_addr);
    end
    tick;
    checks++;
    if ({mem_rd, mem_wr, c_ack, d_ack} !== 4'b0000) begin
      errors++;
      $display("FAIL t1_wait: got %b want 0000", {mem_rd, mem_wr, c_ack, d_ack});
    end
    tick;
    checks++;
    if ({c_ack, d_ack} !== 2'b10 || c_rdata !== 16'hBEEF) begin
      errors++;
      $display("FAIL t1_ack: got ack %b rdata %h want 10 BEEF", {c_ack, d_ack}, c_rdata);
    end
    c_req = 1'b0;
    tick;
    checks++;
    if ({c_ack, busy} !== 2'b00) begin
      errors++;
      $display("FAIL t1_idle: got %b want 00", {c_ack, busy});
    end
  endtask

  task automatic test_dbg_write;
    d_req = 1'b1; d_wr = 1'b1; d_addr = 12'h0FF; d_wdata = 16'h1234;
    tick;
    checks++;
    if ({mem_rd, mem_wr, owner} !== 3'b011 || mem_addr !== 12'h0FF || mem_wdata !== 16'h1234) begin
      errors++;
      $display("FAIL t2_access: got %b %h %h want 011 0FF 1234", {mem_rd, mem_wr, owner}, mem_addr, mem_wdata);
    end
    tick;
    checks++;
    if ({c_ack, d_ack} !== 2'b01) begin
      errors++;
      $display("FAIL t2_ack: got %b want 01", {c_ack, d_ack});
    end
    checks++;
    if (c_rdata !== 16'hBEEF || d_rdata !== 16'h0000) begin
      errors++;
      $display("FAIL t2_rdata: got %h %h want BEEF 0000", c_rdata, d_rdata);
    end
    d_req = 1'b0; d_wr = 1'b0;
    tick;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL t2_idle: busy got %b want 0", busy);
    end
  endtask

  task automatic test_round_robin;
    logic [3:0] ord;
    int cyc [4];
    int n;
    bit coincide;
    ord = '0; n = 0; coincide = 1'b0;
    Reset = 1'b1;
    c_req = 1'b1; c_wr = 1'b0; c_addr = 12'h010;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 12'h020;
    tick; tick;
    Reset = 1'b0;
    for (int k = 1; k <= 40 && n < 4; k++) begin
      tick;
      if (c_ack && d_ack) coincide = 1'b1;
      if (c_ack || d_ack) begin
        ord[n] = d_ack;
        cyc[n] = k;
        n++;
      end
    end
    c_req = 1'b0; d_req = 1'b0;
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL t3_count: got %0d acks want 4", n);
    end
    checks++;
    if (ord !== 4'b1010 || coincide) begin
      errors++;
      $display("FAIL t3_order: got %b coincide %0d want 1010 coincide 0", ord, coincide);
    end
    checks++;
    if (n == 4 && (cyc[0] != 3 || cyc[1] != 7 || cyc[2] != 11 || cyc[3] != 15)) begin
      errors++;
      $display("FAIL t3_timing: got %0d %0d %0d %0d want 3 7 11 15", cyc[0], cyc[1], cyc[2], cyc[3]);
    end
    checks++;
    if (c_rdata !== 16'hC010 || d_rdata !== 16'hC020) begin
      errors++;
      $display("FAIL t3_rdata: got %h %h want C010 C020", c_rdata, d_rdata);
    end
    tick;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL t3_idle: busy got %b want 0", busy);
    end
  endtask

  task automatic test_reset_mid;
    bit acked;
    acked = 1'b0;
    c_req = 1'b1; c_wr = 1'b0; c_addr = 12'h005;
    tick; tick;
    checks++;
    if ({busy, mem_rd, c_ack} !== 3'b100) begin
      errors++;
      $display("FAIL t4_wait: got %b want 100", {busy, mem_rd, c_ack});
    end
    Reset = 1'b1; c_req = 1'b0;
    tick;
    checks++;
    if ({busy, owner, c_ack, d_ack, mem_rd, mem_wr} !== 6'b010000) begin
      errors++;
      $display("FAIL t4_ctl: got %b want 010000", {busy, owner, c_ack, d_ack, mem_rd, mem_wr});
    end
    checks++;
    if ({mem_addr, mem_wdata, c_rdata, d_rdata} !== 60'h0) begin
      errors++;
      $display("FAIL t4_data: got %h want 0", {mem_addr, mem_wdata, c_rdata, d_rdata});
    end
    Reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick;
      if (c_ack || busy) acked = 1'b1;
    end
    checks++;
    if (acked) begin
      errors++;
      $display("FAIL t4_noack: got late ack/busy 1 want 0");
    end
  endtask

  task automatic test_lat3;
    int lat;
    lat = -1;
    k_c_req = 1'b1; k_c_addr = 12'h044;
    for (int k = 1; k <= 20; k++) begin
      tick;
      if (k_c_ack) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (lat != 5) begin
      errors++;
      $display("FAIL t5_latency: got %0d want 5", lat);
    end
    checks++;
    if (k_c_rdata !== 16'hC044 || {k_busy, k_owner, k_d_ack, k_mem_wr} !== 4'b1000) begin
      errors++;
      $display("FAIL t5_data: got %h %b want C044 1000", k_c_rdata, {k_busy, k_owner, k_d_ack, k_mem_wr});
    end
    checks++;
    if (k_d_rdata !== 16'h0000 || k_mem_wdata !== 16'h0000) begin
      errors++;
      $display("FAIL t5_untouched: got %h %h want 0000 0000", k_d_rdata, k_mem_wdata);
    end
    k_c_req = 1'b0;
    tick;
  endtask

`ifdef MU0_ARB_LOCK_EN
  task automatic test_lock;
    logic [3:0] ord;
    int n;
    bit first;
    ord = '0; n = 0; first = 1'b0;
    Reset = 1'b1;
    tick; tick;
    Reset = 1'b0;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 12'h030;
    for (int k = 0; k < 20 && !first; k++) begin
      tick;
      if (d_ack) first = 1'b1;
    end
    d_lock = 1'b1; c_req = 1'b1; c_wr = 1'b0; c_addr = 12'h010;
    for (int k = 0; k < 60 && n < 4; k++) begin
      tick;
      if (c_ack || d_ack) begin
        ord[n] = d_ack;
        n++;
        if (n == 3) d_lock = 1'b0;
      end
    end
    c_req = 1'b0; d_req = 1'b0; d_lock = 1'b0;
    checks++;
    if (!first || n != 4 || ord !== 4'b0111) begin
      errors++;
      $display("FAIL t6_lock: got first %0d n %0d order %b want 1 4 0111", first, n, ord);
    end
    tick;
  endtask
`endif

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset = 1'b1;
    c_req = 1'b0; c_wr = 1'b0; c_addr = '0; c_wdata = 16'hA5A5;
    d_req = 1'b0; d_wr = 1'b0; d_addr = '0; d_wdata = '0;
    k_c_req = 1'b0; k_c_addr = '0;
`ifdef MU0_ARB_LOCK_EN
    d_lock = 1'b0;
`endif
    test_reset;
    test_core_read;
    test_dbg_write;
    test_round_robin;
    test_reset_mid;
    test_lat3;
`ifdef MU0_ARB_LOCK_EN
    test_lock;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
